// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready, stall hold, flush and optional skid entry
// Ports: clk; rst (async, active-low); stall freezes contents; flush kills held entries;
//   in_valid/in_ready/in_data upstream side; out_valid/out_ready/out_data downstream side;
//   occupancy = number of entries held (0..2).
module pipe_stage_reg #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter bit               SKID       = 1'b1,
    parameter bit               CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    logic fire_in;
    logic fire_out;
    logic skid_valid;
    assign fire_in   = in_valid & in_ready;
    assign fire_out  = out_valid & out_ready & ~stall;
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};
    generate
        if (SKID) begin : g_skid
            state_t           state;
            state_t           state_nx;
            logic [WIDTH-1:0] main_q;
            logic [WIDTH-1:0] skid_q;
            logic             load_main;
            logic             load_skid;
            logic             pop_skid;
            always_ff @(posedge clk or negedge rst)
                if (!rst) state <= EMPTY;
                else      state <= state_nx;
            // stall forces fire_in/fire_out low, so every state holds without a separate branch
            always_comb begin
                state_nx  = state;
                load_main = 1'b0;
                load_skid = 1'b0;
                pop_skid  = 1'b0;
                if (flush) state_nx = EMPTY;
                else case (state)
                    EMPTY: if (fire_in) begin
                        state_nx  = ONE;
                        load_main = 1'b1;
                    end
                    ONE: if (fire_in && fire_out) load_main = 1'b1;
                    else if (fire_in) begin
                        state_nx  = FULL;
                        load_skid = 1'b1;
                    end
                    else if (fire_out) state_nx = EMPTY;
                    FULL: if (fire_out) begin
                        state_nx = ONE;
                        pop_skid = 1'b1;
                    end
                    default: state_nx = EMPTY;
                endcase
            end
            always_ff @(posedge clk or negedge rst)
                if (!rst) begin
                    main_q <= RST_VAL;
                    skid_q <= RST_VAL;
                end else if (flush) begin
                    if (CLEAR_DATA) begin
                        main_q <= RST_VAL;
                        skid_q <= RST_VAL;
                    end
                end else begin
                    if (load_main)     main_q <= in_data;
                    else if (pop_skid) main_q <= skid_q;
                    if (load_skid)     skid_q <= in_data;
                end
            assign out_valid  = state != EMPTY;
            assign skid_valid = state == FULL;
            // registered-only ready: no path from out_ready
            assign in_ready   = ~skid_valid & ~stall & ~flush & rst;
            assign out_data   = main_q;
        end else begin : g_single
            logic             valid_q;
            logic [WIDTH-1:0] main_q;
            always_ff @(posedge clk or negedge rst)
                if (!rst) begin
                    valid_q <= 1'b0;
                    main_q  <= RST_VAL;
                end else if (flush) begin
                    valid_q <= 1'b0;
                    if (CLEAR_DATA) main_q <= RST_VAL;
                end else if (fire_in) begin
                    valid_q <= 1'b1;
                    main_q  <= in_data;
                end else if (fire_out) valid_q <= 1'b0;
            assign out_valid  = valid_q;
            assign skid_valid = 1'b0;
            assign in_ready   = (~valid_q | out_ready) & ~stall & ~flush & rst;
            assign out_data   = main_q;
        end
    endgenerate
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; the generic successor to the fixed per-stage latches between IF/ID/EX/MEM/WB.
- Carries an opaque WIDTH-bit payload (PC, inst, control, results, packed by the instantiating stage) with valid/ready handshaking, DCache-style stall hold, and branch/exception flush.
- SKID=1 adds a second entry so in_ready has no combinational path from out_ready, for timing-critical stage boundaries.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- RST_VAL, 0, payload value loaded on reset and on flush when CLEAR_DATA=1; stages carrying a PC use 32'h1C000000.
- SKID, 1, 1 = two-entry skid buffer with registered ready; 0 = single entry with combinational ready.
- CLEAR_DATA, 1, 1 = flush also loads RST_VAL into the payload registers; 0 = flush clears valid bits only.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  freeze request (e.g. DCache miss); holds stage contents.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  payload held in the main register.
- occupancy  out  2  entries held: 0, 1 or 2 (2 only when SKID=1).

Behaviour:
- Reset (rst=0, asynchronous, any cycle, including mid-transfer): out_valid=0, skid entry invalid, main and skid data=RST_VAL, occupancy=0. in_ready=0 while rst=0.
- Handshake terms: fire_in = in_valid & in_ready; fire_out = out_valid & out_ready & ~stall.
- Payload is never modified. Accepted entries leave in acceptance order, with no loss or duplication.
- Latency: 1 cycle. An entry accepted at edge N is visible on out_data after edge N.
- Priority, highest first: reset, flush, stall, normal flow.
- flush=1: at the edge, out_valid←0 and skid invalid. If CLEAR_DATA=1, both data registers←RST_VAL. in_ready=0 during flush, so an in_valid presented that cycle is not accepted. Flush overrides stall.
- stall=1, flush=0: all registers hold. in_ready=0 and fire_out=0. out_valid and out_data remain driven unchanged.
- SKID=0: in_ready = (~out_valid | out_ready) & ~stall & ~flush & rst.
  - fire_in: main←in_data, out_valid←1.
  - else fire_out: out_valid←0, out_data holds its last value.
- SKID=1: in_ready = ~skid_valid & ~stall & ~flush & rst. No dependence on out_ready.
  - FSM states: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
  - EMPTY: fire_in → main←in, ONE.
  - ONE: fire_in & fire_out → main←in, stay ONE. fire_in only → skid←in, FULL. fire_out only → EMPTY. Neither → hold.
  - FULL: in_ready=0. fire_out → main←skid, ONE. Else hold.
- occupancy = out_valid + skid_valid. It never reads 2 when SKID=0.
- out_valid does not drop while waiting for out_ready; out_data is stable while out_valid & ~out_ready.
- Downstream and upstream may toggle valid/ready freely. The stage itself never retracts out_valid except on flush or reset.

Test Plan:
- Reset/idle: WIDTH=32, RST_VAL=32'h1C000000; hold rst=0, then release → out_valid=0, out_data=32'h1C000000, occupancy=0, in_ready=1 on the first cycle after release.
- Streaming: out_ready=1, inputs 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 one cycle later each, no bubbles, occupancy=1 throughout (both SKID values).
- Skid fill/drain (SKID=1): send A, B with out_ready=0 → occupancy=2 and in_ready=0 after B. Raise out_ready → A then B emitted, and in_ready=1 the cycle after A leaves.
- Stall hold: out_valid=1 holding 32'hDEAD0001, stall=1 for 5 cycles with in_valid=1 and out_ready=1 → out_data unchanged, no acceptance, no output fire. Release → DEAD0001 consumed, the new input accepted.
- Flush during FULL with stall=1 and in_valid=1 → next cycle out_valid=0, occupancy=0, out_data=32'h1C000000 (CLEAR_DATA=1), or the previous data with out_valid=0 (CLEAR_DATA=0); the flushed input is not accepted.
- Async reset mid-transfer: assert rst=0 between edges while FULL → outputs return to reset values immediately, without waiting for a clock edge.
